// File: rtl/io_input_conditioner_if.sv
// Raw board inputs and their debounced levels and change strobe.
// master drives the raw pins; slave is the conditioner.
interface io_input_conditioner_if #(
  parameter int N_GPIO = 36,
  parameter int N_SW   = 4
);
  logic [N_GPIO-1:0]      gpio_raw;
  logic [N_SW-1:0]        sw_raw;
  logic [N_GPIO-1:0]      gpio_clean;
  logic [N_SW-1:0]        sw_clean;
  logic                   change;
  logic [N_GPIO+N_SW-1:0] change_mask;

  modport master (
    output gpio_raw, sw_raw,
    input  gpio_clean, sw_clean, change, change_mask
  );

  modport slave (
    input  gpio_raw, sw_raw,
    output gpio_clean, sw_clean, change, change_mask
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Per-bit synchronizer + tick-sampled debounce; latency SYNC_STAGES cycles + STABLE_TICKS ticks.
// change/change_mask pulse one cycle after the clean update; no backpressure, outputs always valid.
module io_input_conditioner #(
  parameter int N_GPIO       = 36,
  parameter int N_SW         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  io_input_conditioner_if.slave   bus
);
  localparam int W  = N_GPIO + N_SW;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [PW-1:0]                 presc_q, presc_d;
  logic [W-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]                  clean_q, clean_d;
  logic [W-1:0]                  upd_q, upd_d;
  logic [W-1:0]                  mask_q, mask_d;
  logic                          change_q, change_d;
  logic                          tick;
  logic [W-1:0]                  sync_bits;

  assign tick      = (presc_q == PRESC_MAX);
  assign sync_bits = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {bus.sw_raw, bus.gpio_raw};
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // A tick that sees sync==clean throws away any partial count, so only an
  // unbroken run of STABLE_TICKS differing samples moves the clean level.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    upd_d   = '0;
    if (tick) begin
      for (int i = 0; i < W; i++) begin
        if (sync_bits[i] == clean_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i]   = '0;
          clean_d[i] = sync_bits[i];
          upd_d[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // upd_q holds the bits flipped on the tick edge; the strobe follows a cycle later.
  always_comb begin
    mask_d   = upd_q;
    change_d = |upd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      presc_q  <= '0;
      cnt_q    <= '0;
      clean_q  <= '0;
      upd_q    <= '0;
      mask_q   <= '0;
      change_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      upd_q    <= upd_d;
      mask_q   <= mask_d;
      change_q <= change_d;
    end
  end

  assign bus.gpio_clean  = clean_q[N_GPIO-1:0];
  assign bus.sw_clean    = clean_q[W-1:N_GPIO];
  assign bus.change      = change_q;
  assign bus.change_mask = mask_q;
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2.
// After each reset release ticks land on edges 4,8,12..; a step held from release is accepted on edge 12.
module tb_io_input_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_input_conditioner_if #(.N_GPIO(36), .N_SW(4)) bus ();

  io_input_conditioner #(
    .N_GPIO(36), .N_SW(4), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_TICKS(3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          rst_first;
    int          cyc;
    logic [35:0] g;
    logic [3:0]  s;
    logic [35:0] eg;
    logic [3:0]  es;
    logic        ec;
    logic [39:0] em;
    string       name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [35:0] G1 = 36'hF_FFFF_FFFF;
  localparam logic [39:0] M1 = 40'hFF_FFFF_FFFF;

  task automatic add(input bit r, input int c, input logic [35:0] g, input logic [3:0] s,
                     input logic [35:0] eg, input logic [3:0] es, input logic ec,
                     input logic [39:0] em, input string n);
    vec_t v;
    v.rst_first = r; v.cyc = c; v.g = g; v.s = s;
    v.eg = eg; v.es = es; v.ec = ec; v.em = em; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [35:0] eg, input logic [3:0] es,
                         input logic ec, input logic [39:0] em);
    chk({name, ".gpio_clean"}, 64'(bus.gpio_clean), 64'(eg));
    chk({name, ".sw_clean"}, 64'(bus.sw_clean), 64'(es));
    chk({name, ".change"}, 64'(bus.change), 64'(ec));
    chk({name, ".change_mask"}, 64'(bus.change_mask), 64'(em));
  endtask

  // Leaves rst released 1ns after an edge, with cyc counting edges from there.
  task automatic do_reset(input logic [35:0] g, input logic [3:0] s);
    bus.gpio_raw = g;
    bus.sw_raw   = s;
    #1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    vec_t v;
    bus.gpio_raw = '0;
    bus.sw_raw   = '0;

    // reset with all inputs high
    add(1, 0,  G1, 4'hF, '0, '0, 0, '0, "rst_rel");
    add(0, 3,  G1, 4'hF, '0, '0, 0, '0, "rst_hold3");
    add(0, 11, G1, 4'hF, '0, '0, 0, '0, "rst_pre");
    add(0, 12, G1, 4'hF, G1, 4'hF, 0, '0, "rst_acc");
    add(0, 13, G1, 4'hF, G1, 4'hF, 1, M1, "rst_chg");
    add(0, 14, G1, 4'hF, G1, 4'hF, 0, '0, "rst_chg_end");
    // clean step on gpio 5
    add(1, 0,  36'h20, 4'h0, '0, '0, 0, '0, "step_start");
    add(0, 11, 36'h20, 4'h0, '0, '0, 0, '0, "step_pre");
    add(0, 12, 36'h20, 4'h0, 36'h20, '0, 0, '0, "step_acc");
    add(0, 13, 36'h20, 4'h0, 36'h20, '0, 1, 40'h20, "step_chg");
    add(0, 14, 36'h20, 4'h0, 36'h20, '0, 0, '0, "step_chg_end");
    // 6-cycle glitch on sw 2
    add(1, 0,  '0, 4'h4, '0, '0, 0, '0, "glitch_start");
    add(0, 6,  '0, 4'h0, '0, '0, 0, '0, "glitch_drop");
    add(0, 8,  '0, 4'h0, '0, '0, 0, '0, "glitch_t8");
    add(0, 12, '0, 4'h0, '0, '0, 0, '0, "glitch_t12");
    add(0, 13, '0, 4'h0, '0, '0, 0, '0, "glitch_t13");
    add(0, 20, '0, 4'h0, '0, '0, 0, '0, "glitch_t20");
    // bounce 1,0,1 on gpio 0 at tick granularity
    add(1, 0,  36'h1, '0, '0, '0, 0, '0, "bounce_hi1");
    add(0, 4,  36'h0, '0, '0, '0, 0, '0, "bounce_lo");
    add(0, 8,  36'h1, '0, '0, '0, 0, '0, "bounce_hi2");
    add(0, 12, 36'h1, '0, '0, '0, 0, '0, "bounce_t12");
    add(0, 16, 36'h1, '0, '0, '0, 0, '0, "bounce_t16");
    add(0, 19, 36'h1, '0, '0, '0, 0, '0, "bounce_pre");
    add(0, 20, 36'h1, '0, 36'h1, '0, 0, '0, "bounce_acc");
    add(0, 21, 36'h1, '0, 36'h1, '0, 1, 40'h1, "bounce_chg");
    add(0, 22, 36'h1, '0, 36'h1, '0, 0, '0, "bounce_chg_end");
    // simultaneous gpio 35 and sw 0
    add(1, 0,  36'h8_0000_0000, 4'h1, '0, '0, 0, '0, "simul_start");
    add(0, 11, 36'h8_0000_0000, 4'h1, '0, '0, 0, '0, "simul_pre");
    add(0, 12, 36'h8_0000_0000, 4'h1, 36'h8_0000_0000, 4'h1, 0, '0, "simul_acc");
    add(0, 13, 36'h8_0000_0000, 4'h1, 36'h8_0000_0000, 4'h1, 1, 40'h18_0000_0000, "simul_chg");
    add(0, 14, 36'h8_0000_0000, 4'h1, 36'h8_0000_0000, 4'h1, 0, '0, "simul_chg_end");

    // outputs held at zero while rst is asserted with raw inputs high
    bus.gpio_raw = G1;
    bus.sw_raw   = 4'hF;
    rst = 1'b1;
    step(3);
    chk_all("in_reset", '0, '0, 0, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst_first) do_reset(v.g, v.s);
      while (cyc < v.cyc) step(1);
      chk_all(v.name, v.eg, v.es, v.ec, v.em);
      bus.gpio_raw = v.g;
      bus.sw_raw   = v.s;
    end

    // reset after two of three ticks on gpio 7: count is lost, full latency again
    do_reset(36'h80, '0);
    while (cyc < 8) step(1);
    chk_all("midrst_pre", '0, '0, 0, '0);
    rst = 1'b1;
    step(1);
    chk_all("midrst_in", '0, '0, 0, '0);
    step(1);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 4) step(1);
    chk_all("midrst_t4", '0, '0, 0, '0);
    while (cyc < 11) step(1);
    chk_all("midrst_pre_acc", '0, '0, 0, '0);
    step(1);
    chk_all("midrst_acc", 36'h80, '0, 0, '0);
    step(1);
    chk_all("midrst_chg", 36'h80, '0, 1, 40'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
